d_mem_sized: RTL

Parametrised multi-cycle data memory that succeeds the single-cycle word-only RAM. It serves MIPS load/store accesses of byte, half and word size (lb/lbu/lh/lhu/lw/sb/sh/sw) through a valid/ready request channel and a one-cycle response pulse. Depth and access latency are configurable, and misaligned, out-of-range and illegal-size accesses return an error flag. It sits between the MEM stage control and the datapath and replaces the combinational-read RAM.

---
 rtl/d_mem_sized_pkg.sv | 23 ++
 rtl/d_mem_sized_lane_align.sv | 70 +++++++
 rtl/d_mem_sized.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/d_mem_sized_pkg.sv
// Shared definitions for the sized data memory.
// Holds the access-size encodings, the default depth, the latency ceiling
// and the FSM state constants used by d_mem_sized and dmem_lane_align.
package d_mem_sized_pkg;

    // Default number of 32-bit words in the array.
    localparam int DMEM_SIZE = 1024;

    // Largest supported number of wait cycles (width of the wait counter).
    localparam int LATENCY_MAX = 15;

    // req_size encodings.
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Access FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/d_mem_sized_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering for the data memory.
// Ports:
//   size_i        access size (byte/half/word/illegal)
//   addr_lo_i     byte offset within the word
//   unsigned_i    zero-extend (1) or sign-extend (0) loads
//   wdata_i       right-aligned store data
//   rdata_i       raw 32-bit word read from the array
//   be_o          per-byte write enables (little-endian lanes)
//   wdata_lane_o  store data replicated so each lane sees its bytes
//   rdata_ext_o   extracted and extended load data
//   misalign_o    half on odd address, or word not on a 4-byte boundary
module dmem_lane_align
    import d_mem_sized_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Decode lane enables, position store data and extend load data by size.
    always_comb begin
        be_o         = 4'b0000;
        wdata_lane_o = 32'h0000_0000;
        rdata_ext_o  = 32'h0000_0000;
        misalign_o   = 1'b0;
        byte_s       = rdata_i[8*addr_lo_i +: 8];
        half_s       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_BYTE: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_lane_o = {4{wdata_i[7:0]}};
                if (unsigned_i) begin
                    rdata_ext_o = {24'h00_0000, byte_s};
                end else begin
                    rdata_ext_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SIZE_HALF: begin
                misalign_o   = addr_lo_i[0];
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_lane_o = {2{wdata_i[15:0]}};
                if (unsigned_i) begin
                    rdata_ext_o = {16'h0000, half_s};
                end else begin
                    rdata_ext_o = {{16{half_s[15]}}, half_s};
                end
            end
            SIZE_WORD: begin
                misalign_o   = (addr_lo_i != 2'b00);
                be_o         = 4'b1111;
                wdata_lane_o = wdata_i;
                rdata_ext_o  = rdata_i;
            end
            default: begin
                // Illegal size: no lanes, no data; the top flags the error.
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/d_mem_sized.sv
// d_mem_sized: multi-cycle byte/half/word data memory with a valid/ready
// request channel and a one-cycle response pulse.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_write, req_size,
//   req_unsigned, req_addr,
//   req_wdata                      request fields, latched on acceptance
//   rsp_valid                      one-cycle pulse on completion
//   rsp_rdata                      extended load data (0 for stores/errors)
//   rsp_error                      access rejected (size, alignment, range)
module d_mem_sized
    import d_mem_sized_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_SIZE,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int                IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]        LAT_CNT     = 4'(LATENCY);
    localparam longint unsigned   LIMIT_BYTES = longint'(DEPTH_WORDS) * 64'd4;

    // Array contents start at zero and are deliberately untouched by reset.
    logic [31:0] mem_array [DEPTH_WORDS] = '{default: 32'h0000_0000};

    logic [1:0]        state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              write_q,     write_d;
    logic [1:0]        size_q,      size_d;
    logic              unsigned_q,  unsigned_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    logic              accept_s;
    logic              commit_s;
    logic              out_of_range_s;
    logic              error_s;
    logic [IDX_W-1:0]  word_idx_s;
    logic [31:0]       raw_word_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_lane_s;
    logic [31:0]       rdata_ext_s;
    logic              misalign_s;

    assign accept_s       = req_valid && req_ready_q;
    assign commit_s       = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    assign word_idx_s     = addr_q[IDX_W+1:2];
    assign raw_word_s     = mem_array[word_idx_s];
    assign out_of_range_s = (64'(addr_q) >= LIMIT_BYTES);
    assign error_s        = (size_q == SIZE_ILLEGAL) || misalign_s || out_of_range_s;

    dmem_lane_align u_lane_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .wdata_i      (wdata_q),
        .rdata_i      (raw_word_s),
        .be_o         (be_s),
        .wdata_lane_o (wdata_lane_s),
        .rdata_ext_o  (rdata_ext_s),
        .misalign_o   (misalign_s)
    );

    // Next-state logic: FSM, wait counter, request latch and response data.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        if (accept_s) begin
            write_d    = req_write;
            size_d     = req_size;
            unsigned_d = req_unsigned;
            addr_d     = req_addr;
            wdata_d    = req_wdata;
        end else begin
            write_d    = write_q;
        end
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT_CNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = ST_RESP;
                    rsp_error_d = error_s;
                    rsp_rdata_d = (error_s || write_q) ? 32'h0000_0000 : rdata_ext_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the upcoming state so they carry no decode glitches.
        req_ready_d = (state_d != ST_BUSY);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Byte-lane store commit; only enabled lanes of an error-free store change.
    always_ff @(posedge clock) begin
        if (commit_s && write_q && !error_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_array[word_idx_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule
